// File: rtl/fetch_stage.sv
// Fetch stage: PC, instruction register and opcode predecode for the control decoder.
// Optional macro FETCH_ILLEGAL_TRAP_EN halts on opidx 24..30 and flags illegal.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  imem_addr,
    output logic        imem_re,
    input  logic [17:0] imem_rdata,
    output logic [26:0] opcode_o,
    output logic [7:0]  imm_o,
    output logic [7:0]  pc_o,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pc_mux,
    input  logic        pc_we,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        HOLD,
        HALT
    } state_t;

    state_t      state;
    logic [7:0]  pc;
    logic [4:0]  opidx;
    logic [22:0] onehot;
    logic        bad_op;
    logic        trap_ill;
    logic        stop;
    logic        unused_rsvd;

    assign opidx       = imem_rdata[17:13];
    assign unused_rsvd = imem_rdata[8];
    assign imem_addr   = pc;

    always_comb begin
        onehot = '0;
        for (int i = 0; i < 23; i++)
            onehot[i] = (opidx == 5'(i + 1));
    end

    assign bad_op = (opidx >= 5'd24) && (opidx != 5'd31);

`ifdef FETCH_ILLEGAL_TRAP_EN
    assign trap_ill = bad_op;
`else
    // Unknown opcodes fall through as NOOPs: onehot is already zero.
    assign trap_ill = 1'b0 & bad_op;
`endif

    assign stop = (opidx == 5'd31) || trap_ill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            imem_re     <= 1'b0;
            opcode_o    <= '0;
            imm_o       <= '0;
            pc_o        <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state   <= FETCH;
                    imem_re <= 1'b1;
                end
                FETCH: begin
                    state   <= CAPTURE;
                    imem_re <= 1'b0;
                end
                CAPTURE: begin
                    if (stop) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        illegal <= trap_ill;
                    end else begin
                        state       <= HOLD;
                        instr_valid <= 1'b1;
                        opcode_o    <= {imem_rdata[12:11],
                                        imem_rdata[10:9],
                                        onehot};
                        imm_o       <= imem_rdata[7:0];
                        pc_o        <= pc;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        state       <= FETCH;
                        imem_re     <= 1'b1;
                        instr_valid <= 1'b0;
                        opcode_o    <= '0;
                        if (pc_we)
                            pc <= pc_mux ? imm_o : pc + 8'd1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: predecode table, corner sequences
// and a randomized run against a PC-level reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  imem_addr;
    logic        imem_re;
    logic [17:0] imem_rdata;
    logic [26:0] opcode_o;
    logic [7:0]  imm_o;
    logic [7:0]  pc_o;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_mux;
    logic        pc_we;
    logic        halted;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    logic [17:0] imem [256];

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_re    (imem_re),
        .imem_rdata (imem_rdata),
        .opcode_o   (opcode_o),
        .imm_o      (imm_o),
        .pc_o       (pc_o),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc_mux     (pc_mux),
        .pc_we      (pc_we),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (imem_re) imem_rdata <= imem[imem_addr];

    typedef struct {
        logic [4:0]  op;
        logic [1:0]  x;
        logic [1:0]  y;
        logic [7:0]  imm;
        logic        valid;
        logic [22:0] oh;
        logic        halt;
        logic        ill;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] word(input logic [4:0] op,
                                         input logic [1:0] x,
                                         input logic [1:0] y,
                                         input logic [7:0] imm);
        return {op, x, y, 1'b0, imm};
    endfunction

    // Reference predecode: one bit per opcode number, shifted into place.
    function automatic logic [26:0] pred(input logic [17:0] w);
        logic [22:0] oh;
        int op;
        op = int'(w[17:13]);
        oh = '0;
        if (op >= 1 && op <= 23) oh = 23'(1) << (op - 1);
        return {w[12:11], w[10:9], oh};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        instr_ready = 1'b0;
        pc_we = 1'b0;
        pc_mux = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (instr_valid) ok = 1;
        end
        chk({name, "_valid_timeout"}, 32'(ok), 32'd1);
    endtask

    // Called at a negedge while valid; leaves us at posedge+1 (FETCH).
    task automatic accept(input logic we, input logic mux);
        instr_ready = 1'b1;
        pc_we = we;
        pc_mux = mux;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        pc_we = 1'b0;
        pc_mux = 1'b0;
    endtask

    logic [26:0] s_op;
    logic [7:0]  s_imm;
    logic [7:0]  s_pc;
    logic [7:0]  mpc;
    int          gap;
    bit          found;
    bit          quiet;

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 18'($urandom);
        rst = 1'b1;
        instr_ready = 1'b0;
        pc_we = 1'b0;
        pc_mux = 1'b0;

        vecs[0] = '{5'd7,  2'd1, 2'd2, 8'h00, 1'b1, 23'h000040, 1'b0, 1'b0};
        vecs[1] = '{5'd0,  2'd3, 2'd3, 8'h5A, 1'b1, 23'h000000, 1'b0, 1'b0};
        vecs[2] = '{5'd1,  2'd0, 2'd1, 8'hFF, 1'b1, 23'h000001, 1'b0, 1'b0};
        vecs[3] = '{5'd12, 2'd2, 2'd0, 8'h33, 1'b1, 23'h000800, 1'b0, 1'b0};
        vecs[4] = '{5'd23, 2'd1, 2'd1, 8'h80, 1'b1, 23'h400000, 1'b0, 1'b0};
        vecs[5] = '{5'd18, 2'd0, 2'd0, 8'h10, 1'b1, 23'h020000, 1'b0, 1'b0};
`ifdef FETCH_ILLEGAL_TRAP_EN
        vecs[6] = '{5'd25, 2'd2, 2'd1, 8'h11, 1'b0, 23'h000000, 1'b1, 1'b1};
`else
        vecs[6] = '{5'd25, 2'd2, 2'd1, 8'h11, 1'b1, 23'h000000, 1'b0, 1'b0};
`endif
        vecs[7] = '{5'd31, 2'd0, 2'd0, 8'h00, 1'b0, 23'h000000, 1'b1, 1'b0};

        // Outputs while reset is held, memory holds garbage.
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_re", 32'(imem_re), 32'd0);
        chk("rst_opcode", 32'(opcode_o), 32'd0);
        chk("rst_imm_pc", {16'd0, imm_o, pc_o}, 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_flags", {30'd0, halted, illegal}, 32'd0);

        foreach (vecs[k]) begin
            imem[0] = word(vecs[k].op, vecs[k].x, vecs[k].y, vecs[k].imm);
            do_reset();
            @(posedge clk);
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", k), 32'(instr_valid),
                32'(vecs[k].valid));
            chk($sformatf("vec%0d_opcode", k), 32'(opcode_o),
                vecs[k].valid ? 32'({vecs[k].x, vecs[k].y, vecs[k].oh})
                              : 32'd0);
            if (vecs[k].valid) begin
                chk($sformatf("vec%0d_imm", k), 32'(imm_o), 32'(vecs[k].imm));
                chk($sformatf("vec%0d_pc", k), 32'(pc_o), 32'd0);
            end
            chk($sformatf("vec%0d_halted", k), 32'(halted),
                32'(vecs[k].halt));
            chk($sformatf("vec%0d_illegal", k), 32'(illegal),
                32'(vecs[k].ill));
            if (vecs[k].halt) begin
                quiet = 1;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    if (imem_re || !halted || instr_valid) quiet = 0;
                end
                chk($sformatf("vec%0d_halt_quiet", k), 32'(quiet), 32'd1);
            end
        end

        // Sequential PC, stall in HOLD, jumps and wraparound.
        imem[0]    = word(5'd7, 2'd1, 2'd2, 8'h00);
        imem[1]    = word(5'd1, 2'd3, 2'd0, 8'hC3);
        imem[2]    = word(5'd0, 2'd0, 2'd0, 8'h00);
        imem[3]    = word(5'd18, 2'd0, 2'd0, 8'h10);
        imem[8'h10] = word(5'd18, 2'd0, 2'd0, 8'hFF);
        imem[8'hFF] = word(5'd2, 2'd1, 2'd1, 8'h44);
        do_reset();
        wait_valid("seq0");
        chk("seq0_pc", 32'(pc_o), 32'd0);
        accept(1'b1, 1'b0);
        chk("seq0_next", {23'd0, imem_re, imem_addr}, 32'h101);
        wait_valid("seq1");
        s_op = opcode_o;
        s_imm = imm_o;
        s_pc = pc_o;
        chk("seq1_pc", 32'(s_pc), 32'd1);
        for (int c = 0; c < 5; c++) begin
            instr_ready = 1'b0;
            pc_we = 1'($urandom);
            pc_mux = 1'($urandom);
            @(negedge clk);
            chk($sformatf("stall%0d", c),
                {instr_valid, imem_re, 3'd0, opcode_o},
                {1'b1, 1'b0, 3'd0, s_op});
            chk($sformatf("stall%0d_imm_pc", c), {16'd0, imm_o, pc_o},
                {16'd0, s_imm, s_pc});
        end
        accept(1'b1, 1'b0);
        chk("stall_next", {23'd0, imem_re, imem_addr}, 32'h102);
        wait_valid("seq2");
        accept(1'b1, 1'b0);
        wait_valid("seq3");
        chk("jump_pc", 32'(pc_o), 32'd3);
        accept(1'b1, 1'b1);
        chk("jump_next", {23'd0, imem_re, imem_addr}, 32'h110);
        wait_valid("seq10");
        accept(1'b1, 1'b1);
        chk("jump_ff", {23'd0, imem_re, imem_addr}, 32'h1FF);
        wait_valid("seqff");
        chk("ff_pc", 32'(pc_o), 32'hFF);
        accept(1'b1, 1'b0);
        chk("wrap_next", {23'd0, imem_re, imem_addr}, 32'h100);
        wait_valid("seqw");
        accept(1'b0, 1'b1);
        chk("nowe_next", {23'd0, imem_re, imem_addr}, 32'h100);

        // Reset in the middle of HOLD at pc 5.
        imem[0] = word(5'd18, 2'd0, 2'd0, 8'h05);
        imem[5] = word(5'd2, 2'd2, 2'd2, 8'h77);
        do_reset();
        wait_valid("r0");
        accept(1'b1, 1'b1);
        wait_valid("r5");
        chk("r5_pc", 32'(pc_o), 32'd5);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        found = 0;
        for (int c = 0; c < 5 && !found; c++) begin
            @(posedge clk);
            #1;
            if (imem_re) found = 1;
        end
        chk("midrst_fetch", {23'd0, found, imem_addr}, 32'h100);

        // Randomized run against the PC-level model.
        for (int i = 0; i < 256; i++)
            imem[i] = {5'($urandom_range(0, 23)), 13'($urandom)};
        do_reset();
        mpc = 8'd0;
        gap = 0;
        for (int c = 0; c < 600; c++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            pc_we = ($urandom_range(0, 4) != 0);
            pc_mux = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (imem_re)
                chk("rnd_addr", 32'(imem_addr), 32'(mpc));
            if (instr_valid) begin
                gap = 0;
                chk("rnd_pc", 32'(pc_o), 32'(mpc));
                chk("rnd_opcode", 32'(opcode_o), 32'(pred(imem[mpc])));
                chk("rnd_imm", 32'(imm_o), 32'(imem[mpc][7:0]));
                if (instr_ready && pc_we)
                    mpc = pc_mux ? imem[mpc][7:0] : mpc + 8'd1;
            end else begin
                gap++;
                if (c > 4 && gap > 2)
                    chk("rnd_throughput_gap", 32'(gap), 32'd2);
            end
            @(posedge clk);
            #1;
        end
        instr_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The port list SHALL be: clk  input  1  single system clock, rising-edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 imem_addr  output  8  instruction memory read address, equal to the current PC.
REQ-004 imem_re  output  1  instruction memory read enable.
REQ-005 imem_rdata  input  18  instruction word, valid the cycle after imem_re; fields [17:13] opidx, [12:11] x, [10:9] y, [8] reserved, [7:0] imm.
REQ-006 opcode_o  output  27  predecoded word for the control decoder: {x, y, onehot[22:0]}.
REQ-007 imm_o  output  8  immediate or branch target of the held instruction.
REQ-008 pc_o  output  8  address of the held instruction.
REQ-009 instr_valid  output  1  the held instruction is presented to the control decoder.
REQ-010 instr_ready  input  1  the consumer accepts the held instruction this cycle.
REQ-011 pc_mux  input  1  control decoder output; 1 selects imm_o as the next PC.
REQ-012 pc_we  input  1  control decoder output; 1 allows the PC to update on accept.
REQ-013 halted  output  1  the fetch stage is stopped.
REQ-014 illegal  output  1  the stop was caused by an illegal opidx.

Function
REQ-015 The FSM SHALL have four states: IDLE, FETCH, CAPTURE, HOLD, plus a HALT state.
- IDLE -> FETCH unconditionally.
- FETCH: imem_re=1, imem_addr=PC; next state CAPTURE.
- CAPTURE: latch imem_rdata into the IR; next state HOLD, or HALT per REQ-019/REQ-026.
- HOLD: instr_valid=1; stays in HOLD while instr_ready=0.
REQ-016 Accept occurs in HOLD when instr_ready=1, and the next state SHALL be FETCH; the minimum throughput is 1 instruction per 3 cycles.
REQ-017 On accept, the next PC SHALL be:
- imm_o if pc_we=1 and pc_mux=1;
- PC+1 modulo 256 if pc_we=1 and pc_mux=0;
- PC unchanged if pc_we=0.
REQ-018 onehot[opidx-1] SHALL be 1 for opidx 1..23 and all other onehot bits 0; opidx 0 SHALL give onehot all zeros (NOOP).
REQ-019 opidx 31 (HALT) SHALL move CAPTURE to HALT with instr_valid=0 and halted=1; HALT SHALL be left only by rst.
REQ-020 In HOLD, opcode_o, imm_o and pc_o SHALL remain stable, and pc_mux and pc_we SHALL be ignored unless instr_ready=1.
REQ-021 Outside HOLD, instr_valid SHALL be 0; in FETCH and CAPTURE, opcode_o SHALL be all zeros.
REQ-022 imem_re SHALL be 1 only in FETCH.

Reset
REQ-023 While rst=1 at a clock edge, the next state SHALL be IDLE and:
- PC=0 and IR=0;
- instr_valid=0, imem_re=0, halted=0, illegal=0;
- opcode_o=0, imm_o=0, pc_o=0, imem_addr=0.
REQ-024 Reset in any state, including mid-HOLD or HALT, SHALL abandon the in-flight instruction, and fetch SHALL restart at address 0 two cycles after rst deasserts.
REQ-025 The values of imem_rdata during reset SHALL be ignored.

Configuration
REQ-026 Macro FETCH_ILLEGAL_TRAP_EN:
- Defined: opidx 24..30 in CAPTURE SHALL go to HALT with halted=1 and illegal=1.
- Undefined: opidx 24..30 SHALL be presented as a NOOP (onehot=0, x and y passed through), and illegal SHALL tie to 0.

Verification
REQ-027 Reset, imem[0] = ADD with opidx=7, x=1, y=2, instr_ready=1 -> in cycle 3 after reset release: instr_valid=1, opcode_o={2'b01, 2'b10, 23'h000040}, pc_o=0.
REQ-028 imem[3] = JUMP with opidx=18, imm=0x10; on accept drive pc_mux=1, pc_we=1 -> the next FETCH drives imem_addr=0x10.
REQ-029 instr_ready=0 for 5 cycles in HOLD -> instr_valid stays 1, outputs stay stable, imem_re=0; on the 6th cycle, ready=1 gives accept and then FETCH of PC+1.
REQ-030 PC=0xFF accepted with pc_we=1 and pc_mux=0 -> the next imem_addr=0x00.
REQ-031 opidx=25 fetched -> with the macro: halted=1, illegal=1, and no further imem_re; without the macro: instr_valid=1 and opcode_o[22:0]=0.
REQ-032 rst asserted for 1 cycle during HOLD at pc=0x05 -> instr_valid=0 the next cycle, then the first FETCH uses imem_addr=0x00.
